conv2_sched: RTL and testbench



---
 rtl/conv2_sched.sv | 145 ++++++++++++++
 tb/tb_conv2_sched.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_sched.sv
// conv2 layer sequencer: walks oc/row/col/cp/kr/kc and issues dual-lane weight/feature reads.
// Strobes mac_en/mac_clr trail an issue by RD_LAT cycles and out_we by RD_LAT+1; en=0 stalls issue only.
module conv2_sched #(
    parameter int IN_DIM  = 14,
    parameter int K       = 5,
    parameter int OUT_DIM = 10,
    parameter int OUT_CH  = 16,
    parameter int RD_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        en,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [11:0] w_addr0,
    output logic [11:0] w_addr1,
    output logic [10:0] f_addr0,
    output logic [10:0] f_addr1,
    output logic        mac_clr,
    output logic        mac_en,
    output logic        out_we,
    output logic [10:0] out_addr
);

    localparam int LANE_TAPS = 3 * K * K;
    localparam int F_LANE    = 3 * IN_DIM * IN_DIM;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state, state_nx;
    logic [2:0]  kc, kr, n_kc, n_kr;
    logic [1:0]  cp, n_cp;
    logic [3:0]  col, row, oc, n_col, n_row, n_oc;
    logic [1:0]  dcnt;
    logic        issue;
    logic        c0, c1, c2, c3, c4, c5;
    logic        first_tap;
    logic [11:0] w_nx;
    logic [10:0] f_nx;
    logic [10:0] pix_addr;

    logic [1:0]  rd_dl [RD_LAT];
    logic [11:0] wr_dl [RD_LAT+1];

    assign issue = (state == RUN) && en;

    // carry chain: cN means every loop up to level N is at its last value
    assign c0 = (kc == 3'(K - 1));
    assign c1 = c0 && (kr == 3'(K - 1));
    assign c2 = c1 && (cp == 2'd2);
    assign c3 = c2 && (col == 4'(OUT_DIM - 1));
    assign c4 = c3 && (row == 4'(OUT_DIM - 1));
    assign c5 = c4 && (oc == 4'(OUT_CH - 1));

    assign first_tap = (kc == 3'd0) && (kr == 3'd0) && (cp == 2'd0);

    always_comb begin
        n_kc = c0 ? 3'd0 : kc + 3'd1;
        n_kr = kr;
        n_cp = cp;
        n_col = col;
        n_row = row;
        n_oc = oc;
        if (c0) n_kr = c1 ? 3'd0 : kr + 3'd1;
        if (c1) n_cp = c2 ? 2'd0 : cp + 2'd1;
        if (c2) n_col = c3 ? 4'd0 : col + 4'd1;
        if (c3) n_row = c4 ? 4'd0 : row + 4'd1;
        if (c4) n_oc = c5 ? 4'd0 : oc + 4'd1;
    end

    assign w_nx = 12'(n_oc) * 12'(2 * LANE_TAPS) + 12'(n_cp) * 12'(K * K)
                + 12'(n_kr) * 12'(K) + 12'(n_kc);
    assign f_nx = 11'(n_cp) * 11'(IN_DIM * IN_DIM)
                + (11'(n_row) + 11'(n_kr)) * 11'(IN_DIM) + 11'(n_col) + 11'(n_kc);
    assign pix_addr = 11'(oc) * 11'(OUT_DIM * OUT_DIM) + 11'(row) * 11'(OUT_DIM) + 11'(col);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (issue && c5) state_nx = DRAIN;
            DRAIN:   if (dcnt == 2'(RD_LAT)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            kc <= '0; kr <= '0; cp <= '0;
            col <= '0; row <= '0; oc <= '0;
            w_addr0 <= '0; w_addr1 <= '0;
            f_addr0 <= '0; f_addr1 <= '0;
        end else if (state == IDLE && start) begin
            kc <= '0; kr <= '0; cp <= '0;
            col <= '0; row <= '0; oc <= '0;
            w_addr0 <= '0;
            w_addr1 <= 12'(LANE_TAPS);
            f_addr0 <= '0;
            f_addr1 <= 11'(F_LANE);
        end else if (issue) begin
            kc <= n_kc; kr <= n_kr; cp <= n_cp;
            col <= n_col; row <= n_row; oc <= n_oc;
            w_addr0 <= w_nx;
            w_addr1 <= w_nx + 12'(LANE_TAPS);
            f_addr0 <= f_nx;
            f_addr1 <= f_nx + 11'(F_LANE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)               dcnt <= '0;
        else if (state != DRAIN) dcnt <= '0;
        else                     dcnt <= dcnt + 2'd1;
    end

    // delay lines run every cycle so strobes stay aligned with the memory pipe during stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LAT; i++)     rd_dl[i] <= '0;
            for (int i = 0; i < RD_LAT + 1; i++) wr_dl[i] <= '0;
        end else begin
            rd_dl[0] <= {issue && first_tap, issue};
            for (int i = 1; i < RD_LAT; i++) rd_dl[i] <= rd_dl[i-1];
            wr_dl[0] <= {issue && c2, pix_addr};
            for (int i = 1; i < RD_LAT + 1; i++) wr_dl[i] <= wr_dl[i-1];
        end
    end

    assign rd_en    = issue;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign mac_en   = rd_dl[RD_LAT-1][0];
    assign mac_clr  = rd_dl[RD_LAT-1][1];
    assign out_we   = wr_dl[RD_LAT][11];
    assign out_addr = wr_dl[RD_LAT][10:0];

endmodule

// File: tb/tb_conv2_sched.sv
// Scoreboard bench for conv2_sched: two output channels keep a full layer run short.
module tb_conv2_sched;

    localparam int RD_LAT = 1;
    localparam int OUT_CH = 2;
    localparam int NPIX   = OUT_CH * 100;
    localparam int ISSUES = NPIX * 75;

    logic        clk = 1'b0;
    logic        reset, start, en;
    logic        busy, done, rd_en, mac_clr, mac_en, out_we;
    logic [11:0] w_addr0, w_addr1;
    logic [10:0] f_addr0, f_addr1, out_addr;

    conv2_sched #(.OUT_CH(OUT_CH), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .en(en),
        .busy(busy), .done(done), .rd_en(rd_en),
        .w_addr0(w_addr0), .w_addr1(w_addr1),
        .f_addr0(f_addr0), .f_addr1(f_addr1),
        .mac_clr(mac_clr), .mac_en(mac_en),
        .out_we(out_we), .out_addr(out_addr)
    );

    always #5 clk = ~clk;

    typedef enum {M_IDLE, M_RUN, M_DRAIN, M_DONE} mst_t;
    typedef struct {int cyc; int w0; int w1; int f0; int f1;} aexp_t;
    typedef struct {int cyc; int clr; int pix;} mexp_t;
    typedef struct {int cyc; int addr;} oexp_t;

    aexp_t aq[$];
    mexp_t mq[$];
    oexp_t oq[$];

    int   n_vec = 0, n_err = 0;
    mst_t ms = M_IDLE;
    int   m_tap, m_pix, m_dcnt, m_issue;
    int   cyc = 0;
    int   start_cyc, done_cyc, pix0_mac, out_cnt, last_out, base_len;
    bit   spot_on = 0;

    int sp_idx [9] = '{0, 1, 2, 5, 25, 74, 75, 7500, ISSUES - 1};
    int sp_w0  [9] = '{0, 1, 2, 5, 25, 74, 0, 150, 224};
    int sp_w1  [9] = '{75, 76, 77, 80, 100, 149, 75, 225, 299};
    int sp_f0  [9] = '{0, 1, 2, 14, 196, 452, 1, 0, 587};
    int sp_f1  [9] = '{588, 589, 590, 602, 784, 1040, 589, 588, 1175};

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic eval_cycle();
        aexp_t a;
        mexp_t m;
        oexp_t o;
        int t_cp, t_kr, t_kc, p_oc, p_row, p_col;
        chk_val("busy", busy, ms != M_IDLE);
        chk_val("done", done, ms == M_DONE);
        chk_val("rd_en", rd_en, (ms == M_RUN) && en);

        if (ms == M_RUN && en) begin
            t_cp = m_tap / 25; t_kr = (m_tap % 25) / 5; t_kc = m_tap % 5;
            p_oc = m_pix / 100; p_row = (m_pix % 100) / 10; p_col = m_pix % 10;
            a.cyc = cyc;
            a.w0 = p_oc * 150 + m_tap;
            a.w1 = a.w0 + 75;
            a.f0 = t_cp * 196 + (p_row + t_kr) * 14 + p_col + t_kc;
            a.f1 = a.f0 + 588;
            aq.push_back(a);
            m.cyc = cyc + RD_LAT; m.clr = (m_tap == 0); m.pix = m_pix;
            mq.push_back(m);
            if (m_tap == 74) begin
                o.cyc = cyc + RD_LAT + 1; o.addr = m_pix;
                oq.push_back(o);
            end
            if (spot_on)
                for (int i = 0; i < 9; i++)
                    if (sp_idx[i] == m_issue) begin
                        chk_val("spot_w0", w_addr0, sp_w0[i]);
                        chk_val("spot_w1", w_addr1, sp_w1[i]);
                        chk_val("spot_f0", f_addr0, sp_f0[i]);
                        chk_val("spot_f1", f_addr1, sp_f1[i]);
                    end
        end

        if (rd_en) begin
            if (aq.size() == 0) chk_val("rd_en_unexpected", 1, 0);
            else begin
                a = aq.pop_front();
                chk_val("rd_cycle", cyc, a.cyc);
                chk_val("w_addr0", w_addr0, a.w0);
                chk_val("w_addr1", w_addr1, a.w1);
                chk_val("f_addr0", f_addr0, a.f0);
                chk_val("f_addr1", f_addr1, a.f1);
            end
        end
        if (mac_en) begin
            if (mq.size() == 0) chk_val("mac_en_unexpected", 1, 0);
            else begin
                m = mq.pop_front();
                chk_val("mac_cycle", cyc, m.cyc);
                chk_val("mac_clr", mac_clr, m.clr);
                if (m.pix == 0) pix0_mac++;
            end
        end else if (mac_clr) chk_val("mac_clr_without_en", 1, 0);
        if (out_we) begin
            if (oq.size() == 0) chk_val("out_we_unexpected", 1, 0);
            else begin
                o = oq.pop_front();
                chk_val("out_cycle", cyc, o.cyc);
                chk_val("out_addr", out_addr, o.addr);
            end
            out_cnt++;
            last_out = out_addr;
        end
        if (done) done_cyc = cyc;

        case (ms)
            M_IDLE: if (start) begin
                ms = M_RUN; m_tap = 0; m_pix = 0; m_issue = 0; start_cyc = cyc;
            end
            M_RUN: if (en) begin
                m_issue++; m_tap++;
                if (m_tap == 75) begin
                    m_tap = 0; m_pix++;
                    if (m_pix == NPIX) begin ms = M_DRAIN; m_dcnt = 0; end
                end
            end
            M_DRAIN: if (m_dcnt == RD_LAT) ms = M_DONE; else m_dcnt++;
            M_DONE: ms = M_IDLE;
        endcase
    endtask

    task automatic step(input logic st, input logic e);
        @(negedge clk);
        start = st;
        en = e;
        #2;
        cyc++;
        eval_cycle();
    endtask

    task automatic check_reset_outputs();
        chk_val("rst_busy", busy, 0);
        chk_val("rst_done", done, 0);
        chk_val("rst_rd_en", rd_en, 0);
        chk_val("rst_mac", {mac_en, mac_clr}, 0);
        chk_val("rst_out_we", out_we, 0);
        chk_val("rst_out_addr", out_addr, 0);
        chk_val("rst_w_addr", {w_addr0, w_addr1}, 0);
        chk_val("rst_f_addr", {f_addr0, f_addr1}, 0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        start = 1'b0;
        en = 1'b1;
        #2 reset = 1'b1;
        #1 check_reset_outputs();
        ms = M_IDLE;
        aq.delete(); mq.delete(); oq.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to_idle(input int budget, input int stall_at, input int en_pct);
        int  n = 0;
        int  stall_left = 0;
        bit  stalled = 0;
        logic e;
        while (ms != M_IDLE && n < budget) begin
            e = (en_pct >= 100) ? 1'b1 : ($urandom_range(99) < en_pct);
            if (stall_at >= 0 && !stalled && ms == M_RUN && m_pix == 0 && m_tap == stall_at) begin
                stall_left = 3;
                stalled = 1;
            end
            if (stall_left > 0) begin
                e = 1'b0;
                stall_left--;
            end
            step(n == 1000, e);
            n++;
        end
        if (ms != M_IDLE) chk_val("run_timeout", 0, 1);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; en = 1'b0;
        #3 reset = 1'b1;
        #1 check_reset_outputs();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 1);

        // unstalled full run with a stray start pulse in the middle
        out_cnt = 0; spot_on = 1; done_cyc = -1;
        step(1, 1);
        run_to_idle(ISSUES + 100, -1, 100);
        spot_on = 0;
        base_len = done_cyc - start_cyc;
        chk_val("run_len", base_len, ISSUES + RD_LAT + 2);
        chk_val("out_we_count", out_cnt, NPIX);
        chk_val("last_out_addr", last_out, NPIX - 1);
        chk_val("queues_empty", aq.size() + mq.size() + oq.size(), 0);
        step(0, 1);

        // three-cycle stall inside pixel 0
        pix0_mac = 0; done_cyc = -1;
        step(1, 1);
        run_to_idle(ISSUES + 100, 40, 100);
        chk_val("stall_run_len", done_cyc - start_cyc, base_len + 3);
        chk_val("pix0_mac_count", pix0_mac, 75);
        chk_val("queues_empty2", aq.size() + mq.size() + oq.size(), 0);

        // random stalls, aborted by reset partway through
        step(1, 1);
        for (int n = 0; n < 40000 && !(ms == M_RUN && m_pix == 150); n++)
            step(1'b0, $urandom_range(99) < 75);
        chk_val("abort_reached", m_pix, 150);
        reset_mid();
        for (int i = 0; i < 4; i++) step(0, 1);

        // restart after abort begins from zeroed counters
        step(1, 1);
        step(0, 1);
        chk_val("restart_w_addr0", w_addr0, 0);
        chk_val("restart_f_addr1", f_addr1, 588);
        for (int i = 0; i < 200; i++) step(0, $urandom_range(1));
        reset_mid();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
